// File: rtl/bit_serial_alu_seq.sv
// Bit-serial ALU sequencer: runs one full-adder/logic slice LSB-first over WIDTH
// clocks and returns result, carry/borrow, signed-overflow and zero flags.
module bit_serial_alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;

  logic             arith_c;
  logic             b_in_c;
  logic             sum_c;
  logic             cout_c;
  logic             slice_out_c;
  logic [WIDTH-1:0] res_next_c;

  // 1-bit ALU slice; SUB inverts B and starts with carry = 1
  always_comb begin
    arith_c     = ~op_q[1];
    b_in_c      = b_sr[0] ^ (op_q == OP_SUB);
    sum_c       = a_sr[0] ^ b_in_c ^ carry;
    cout_c      = (a_sr[0] & b_in_c) | (carry & (a_sr[0] ^ b_in_c));
    slice_out_c = sum_c;
    case (op_q)
      OP_ADD, OP_SUB: slice_out_c = sum_c;
      OP_AND:         slice_out_c = a_sr[0] & b_sr[0];
      OP_XOR:         slice_out_c = a_sr[0] ^ b_sr[0];
    endcase
    // res_sr only keeps the upper WIDTH-1 bits; the full word exists on the last step
    res_next_c = {slice_out_c, res_sr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      op_q     <= OP_ADD;
      cnt      <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            op_q  <= op;
            cnt   <= '0;
            carry <= (op == OP_SUB);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_next_c[WIDTH-1:1];
          carry  <= arith_c & cout_c;
          cnt    <= cnt + CNT_W'(1);
          // MSB step: carry register is the carry into the MSB
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= res_next_c;
            carryout <= arith_c & cout_c;
            overflow <= arith_c & (carry ^ cout_c);
            zero     <= (res_next_c == '0);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Self-checking bench for bit_serial_alu_seq: directed WIDTH=8 vectors and
// sequences, plus randomised WIDTH=16 operations against an arithmetic model.
module tb_bit_serial_alu_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start8, busy8, done8, c8, v8, z8;
  logic [1:0] op8;
  logic [7:0] a8, b8, r8;

  logic        start16, busy16, done16, c16, v16, z16;
  logic [1:0]  op16;
  logic [15:0] a16, b16, r16;

  bit_serial_alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(r8), .carryout(c8), .overflow(v8), .zero(z8)
  );

  bit_serial_alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(r16), .carryout(c16), .overflow(v16), .zero(z16)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  vec_t vecs[6];

  // Launch one WIDTH=8 op from IDLE; returns at the negedge where done is seen
  task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                      output int lat, output int busy_cnt);
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~x; b8 = ~y; op8 = ~o;
    lat = 1;
    busy_cnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Reference model: plain arithmetic on whole words
  task automatic model16(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] r, output logic c, output logic v);
    logic [16:0] s;
    r = '0; c = 1'b0; v = 1'b0;
    case (o)
      2'b00: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[15:0]; c = s[16];
        v = (x[15] == y[15]) && (r[15] != x[15]);
      end
      2'b01: begin
        r = x - y; c = (x >= y);
        v = (x[15] != y[15]) && (r[15] != x[15]);
      end
      2'b10: r = x & y;
      default: r = x ^ y;
    endcase
  endtask

  initial begin
    int lat, bc;
    logic [15:0] er, ra, rb;
    logic ec, ev;
    logic [1:0] ro;

    vecs[0] = '{2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2'b01, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b01, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{2'b11, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 8'hA5, 8'h0F, 8'h05, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_outs", {r8, c8, v8, z8}, 0);
    reset = 1'b0;

    // Directed vectors with latency and busy-window checks
    foreach (vecs[i]) begin
      run8(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
      check($sformatf("v%0d_latency", i), lat, 9);
      check($sformatf("v%0d_busy_cycles", i), bc, 8);
      check($sformatf("v%0d_busy_at_done", i), busy8, 0);
      check($sformatf("v%0d_result", i), r8, vecs[i].res);
      check($sformatf("v%0d_carry", i), c8, vecs[i].c);
      check($sformatf("v%0d_ovf", i), v8, vecs[i].v);
      check($sformatf("v%0d_zero", i), z8, vecs[i].z);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done8, 0);
      check($sformatf("v%0d_result_hold", i), r8, vecs[i].res);
    end

    // Starts in cycles 3 and 9 ignored; start at cycle 10 accepted
    @(negedge clk);
    op8 = 2'b00; a8 = 8'h7F; b8 = 8'h01; start8 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check($sformatf("seq_done_c%0d", c), done8, (c == 9 || c == 19));
      check($sformatf("seq_busy_c%0d", c), busy8, ((c >= 1 && c <= 8) || (c >= 11 && c <= 18)));
      if (c >= 9 && c < 19) check($sformatf("seq_hold_c%0d", c), r8, 8'h80);
      if (c == 9) check("seq_first_flags", {c8, v8, z8}, 3'b010);
      if (c == 19) check("seq_second_result", r8, 8'h05);
      start8 = (c == 3 || c == 9 || c == 10);
      if (c == 10) begin op8 = 2'b10; a8 = 8'hA5; b8 = 8'h0F; end
      else begin op8 = 2'b01; a8 = 8'h33; b8 = 8'h44; end
    end
    start8 = 1'b0;

    // Reset in cycle 4 of a RUN aborts with no done
    @(negedge clk);
    op8 = 2'b00; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy8, 0);
    check("abort_outs", {done8, r8, c8, v8, z8}, 0);
    for (int c = 0; c < 12; c++) begin
      if (c == 0) begin op8 = 2'b00; a8 = 8'h22; b8 = 8'h11; start8 = 1'b1; end
      else start8 = 1'b0;
      @(negedge clk);
      if (c < 8) check($sformatf("abort_nodone_%0d", c), done8, 0);
      if (c == 8) check("restart_done", done8, 1);
      if (c == 8) check("restart_result", r8, 8'h33);
    end

    // Reset and start together: start dropped
    @(negedge clk);
    reset = 1'b1; start8 = 1'b1;
    @(negedge clk);
    reset = 1'b0; start8 = 1'b0;
    @(negedge clk);
    check("rst_start_busy", busy8, 0);

    // Randomised WIDTH=16 against the model; inputs scrambled after acceptance
    for (int n = 0; n < 200; n++) begin
      ro = 2'($urandom_range(3));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 7 == 0) rb = ra;
      model16(ro, ra, rb, er, ec, ev);
      @(negedge clk);
      op16 = ro; a16 = ra; b16 = rb; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); op16 = 2'($urandom);
      lat = 1;
      while (!done16 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("rnd%0d_latency", n), lat, 17);
      check($sformatf("rnd%0d_op%0d_%h_%h", n, ro, ra, rb), {r16, c16, v16, z16},
            {er, ec, ev, er == 16'h0});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serial_alu_seq.md
# bit_serial_alu_seq

Sequencer that runs a single 1-bit ALU slice (full adder plus AND/XOR logic) bit-serially to carry out WIDTH-bit operations. It latches two operands and an opcode on a start strobe, then processes one bit per clock, LSB first, with a registered carry. It returns the result with carry/borrow, signed-overflow and zero flags and a one-cycle done pulse. It sits between the datapath control and the 1-bit ALU slice, and trades area for latency.

## Interface
- WIDTH, 16, operand/result width in bits; legal range ≥ 2.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  2  00 ADD, 01 SUB (a − b), 10 AND, 11 XOR; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle on.
- result  output  WIDTH  operation result; holds until the next accepted start.
- carryout  output  1  ADD: carry out of the MSB. SUB: 1 = no borrow. Logic ops: 0.
- overflow  output  1  signed overflow for ADD/SUB; 0 for logic ops.
- zero  output  1  1 when the latched result == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when start = 1. This cycle latches a into shift register A, b into shift register B, and op. It sets bit counter = 0, and sets carry = 1 for SUB, 0 otherwise.
- Each RUN cycle processes one bit:
  - slice inputs: A[0], B[0] ^ (op==SUB), carry.
  - ADD/SUB output = sum; AND output = A[0] & B[0]; XOR output = A[0] ^ B[0].
  - result_sr <= {slice_out, result_sr[WIDTH-1:1]}; A and B shift right by one.
  - carry <= slice carry-out; for logic ops the carry register stays 0.
- When counter == WIDTH−1, the carry into the MSB (the current carry register) is recorded for overflow. The state then moves RUN → DONE and the counter increments.
- Entering DONE updates result, carryout and overflow. overflow = (carry into MSB) ^ (carry out of MSB), forced to 0 for logic ops. zero = (result == 0).
- DONE → IDLE unconditionally after one cycle. done = 1 only in DONE.
- start is ignored in RUN and DONE; no queuing.
- Changes on a, b or op after acceptance have no effect.
- Arithmetic wraps modulo 2^WIDTH.

## Timing
- Reset values: busy 0, done 0, result 0, carryout 0, overflow 0, zero 0. State = IDLE, counter 0, carry 0.
- Reset asserted at any point, including mid-RUN or in DONE: state returns to IDLE on that edge and all outputs go to reset values. No done is issued for the aborted operation.
- start is high in cycle 0 (IDLE). RUN occupies cycles 1..WIDTH, with busy = 1 in exactly those cycles. done = 1 in cycle WIDTH+1, and busy is 0 there. Total latency from start to done is WIDTH+1 cycles.
- The earliest next accepted start is cycle WIDTH+2 (back in IDLE). Throughput is one operation per WIDTH+2 cycles.
- result and flags are stable from done until the next accepted start, then remain unchanged until the next DONE. Intermediate shift values are not visible on result.
- reset and start high in the same cycle: reset wins and start is dropped.

## Test plan
- WIDTH=8, ADD a=0x7F b=0x01, start at cycle 0 → busy in cycles 1..8, done at cycle 9; result 0x80, carryout 0, overflow 1, zero 0.
- SUB a=0x05 b=0x07 → result 0xFE, carryout 0 (borrow), overflow 0. Then SUB 0x10 − 0x10 → result 0x00, carryout 1, zero 1.
- ADD a=0xFF b=0x01 → result 0x00, carryout 1, overflow 0, zero 1. Then XOR a=0xA5 b=0xFF → 0x5A with carryout/overflow 0. Then AND a=0xA5 b=0x0F → 0x05.
- Assert start again in cycles 3 and 9 with different operands → ignored. The first result is unchanged, and a start at cycle 10 is accepted with done at cycle 19.
- Assert reset in cycle 4 of a RUN → next cycle shows IDLE, all outputs 0, and no done pulse. A start in the cycle after reset is released completes normally with done WIDTH+1 cycles later.
- Randomised ADD/SUB/AND/XOR over WIDTH=16 against a reference model → result and flags match for every operation.
